reg_scoreboard: RTL

- Tracks architectural registers with an outstanding long-latency write (divider, cache-miss load, multi-cycle multiply).
- Sits beside the register file in decode: consumes the decode instruction's register indices and the write-port completion stream.
- Produces a stall so no RAW or WAW hazard reaches a long-latency result before its regfile write.
- Completion is visible in the same cycle it writes the regfile, matching the regfile's write-through forwarding.

---
 rtl/reg_scoreboard_pkg.sv | 14 +
 rtl/reg_scoreboard.sv | 99 +++++++++
 2 files changed

// File: rtl/reg_scoreboard_pkg.sv
// Shared CPU constants for the decode-stage register scoreboard.
package reg_scoreboard_pkg;

  localparam int unsigned REG_IDX_W     = 5;
  localparam int unsigned NUM_ARCH_REGS = 32;

  // Long-latency producer unit ids
  localparam int unsigned UNIT_DIV  = 0;
  localparam int unsigned UNIT_LOAD = 1;
  localparam int unsigned UNIT_MUL  = 2;

  typedef logic [REG_IDX_W-1:0] reg_idx_t;

endpackage

// File: rtl/reg_scoreboard.sv
// Register scoreboard: tracks architectural registers with an outstanding long-latency
// write and stalls decode on RAW/WAW hazards against them or when the tracker is full.
module reg_scoreboard
  import reg_scoreboard_pkg::*;
#(
  parameter int unsigned NUM_UNITS       = 4,
  parameter int unsigned UNIT_W          = 2,
  parameter int unsigned MAX_OUTSTANDING = 4,
  parameter int unsigned CNT_W           = 3
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              issue_valid,
  input  reg_idx_t          issue_rs1_index,
  input  reg_idx_t          issue_rs2_index,
  input  logic              issue_uses_rs1,
  input  logic              issue_uses_rs2,
  input  logic              issue_writes_rd,
  input  reg_idx_t          issue_rd_index,
  input  logic              issue_long,
  input  logic [UNIT_W-1:0] issue_unit,
  input  logic              complete_valid,
  input  reg_idx_t          complete_rd_index,
  input  logic [UNIT_W-1:0] complete_unit,
  output logic              stall,
  output logic              busy,
  output logic [CNT_W-1:0]  outstanding_count,
  output logic              protocol_error
);

  logic [NUM_ARCH_REGS-1:0] pending_q, pending_d;
  logic [UNIT_W-1:0]        owner_q [NUM_ARCH_REGS];
  logic [UNIT_W-1:0]        owner_d [NUM_ARCH_REGS];
  logic [CNT_W-1:0]         count_q, count_d;
  logic                     perr_q, perr_d;

  logic             clr_hit;
  logic             raw_rs1, raw_rs2, waw, cap_full;
  logic             fire, set;
  logic             unit_ok;
  logic [CNT_W-1:0] count_after_clear;

  // Hazard detection with same-cycle completion bypass; stall is purely combinational.
  always_comb begin
    clr_hit = complete_valid && pending_q[complete_rd_index] &&
              (owner_q[complete_rd_index] == complete_unit);
    raw_rs1 = issue_uses_rs1 && (issue_rs1_index != '0) && pending_q[issue_rs1_index] &&
              !(clr_hit && (complete_rd_index == issue_rs1_index));
    raw_rs2 = issue_uses_rs2 && (issue_rs2_index != '0) && pending_q[issue_rs2_index] &&
              !(clr_hit && (complete_rd_index == issue_rs2_index));
    waw     = issue_writes_rd && (issue_rd_index != '0) && pending_q[issue_rd_index] &&
              !(clr_hit && (complete_rd_index == issue_rd_index));
    count_after_clear = count_q - CNT_W'(clr_hit);
    cap_full = issue_long && issue_writes_rd &&
               (count_after_clear == CNT_W'(MAX_OUTSTANDING));
    stall   = issue_valid && (raw_rs1 || raw_rs2 || waw || cap_full);
    fire    = issue_valid && !stall;
    set     = fire && issue_long && issue_writes_rd && (issue_rd_index != '0);
    // A completion tagged with a unit that does not exist is malformed
    unit_ok = ({1'b0, complete_unit} < (UNIT_W + 1)'(NUM_UNITS));
  end

  // Next-state: clear first, then set so a same-register set overrides the clear.
  always_comb begin
    pending_d = pending_q;
    owner_d   = owner_q;
    if (clr_hit) begin
      pending_d[complete_rd_index] = 1'b0;
    end
    if (set) begin
      pending_d[issue_rd_index] = 1'b1;
      owner_d[issue_rd_index]   = issue_unit;
    end
    pending_d[0] = 1'b0;
    count_d = count_q + CNT_W'(set) - CNT_W'(clr_hit);
    // Mismatched completions leave pending state alone and latch the error
    perr_d  = perr_q | (complete_valid && (!clr_hit || !unit_ok));
  end

  // State registers with asynchronous reset dropping all pending writes.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pending_q <= '0;
      owner_q   <= '{default: '0};
      count_q   <= '0;
      perr_q    <= 1'b0;
    end else begin
      pending_q <= pending_d;
      owner_q   <= owner_d;
      count_q   <= count_d;
      perr_q    <= perr_d;
    end
  end

  assign busy              = (count_q != '0);
  assign outstanding_count = count_q;
  assign protocol_error    = perr_q;

endmodule
